// File: rtl/image_ycbcr444_ycbcr422_ds.sv
// rtl/image_ycbcr444_ycbcr422_ds.sv - YCbCr 4:4:4 to 4:2:2 chroma downsampler, three enabled stages
module image_ycbcr444_ycbcr422_ds #(
    parameter int DW       = 8,
    parameter int MODE_AVG = 1,
    parameter int CR_FIRST = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic [DW-1:0] per_img_Y,
    input  logic [DW-1:0] per_img_Cb,
    input  logic [DW-1:0] per_img_Cr,
    output logic          post_frame_vsync,
    output logic          post_frame_href,
    output logic          post_frame_clken,
    output logic [DW-1:0] post_img_Y,
    output logic [DW-1:0] post_img_C,
    output logic          post_odd_line
);

    logic          line_ok;
    logic          last_href;
    logic          phase;
    logic          cur_phase;
    logic          accept;

    logic          s1_vsync, s1_href, s1_phase;
    logic [DW-1:0] s1_y, s1_cb, s1_cr;
    logic          s2_vsync, s2_href, s2_phase;
    logic [DW-1:0] s2_y, s2_cb, s2_cr;
    logic          s3_phase;
    logic [DW-1:0] hold;

    logic          paired;
    logic [DW-1:0] part_cb, part_cr;
    logic [DW:0]   sum_cb, sum_cr;
    logic [DW-1:0] cb_p, cr_p;
    logic [DW-1:0] first_c, second_c;
    logic [DW-1:0] c_next, hold_next;

    // line_ok stays low after reset until href has been seen low, so a line cut by reset is dropped
    assign accept    = per_frame_clken & per_frame_href & line_ok;
    assign cur_phase = last_href ? phase : 1'b0;

    always_comb begin
        paired  = s1_href & s1_phase;
        part_cb = paired ? s1_cb : s2_cb;
        part_cr = paired ? s1_cr : s2_cr;
        sum_cb  = {1'b0, s2_cb} + {1'b0, part_cb} + {{DW{1'b0}}, 1'b1};
        sum_cr  = {1'b0, s2_cr} + {1'b0, part_cr} + {{DW{1'b0}}, 1'b1};
        if (MODE_AVG != 0) begin
            cb_p = DW'(sum_cb >> 1);
            cr_p = DW'(sum_cr >> 1);
        end else begin
            cb_p = s2_cb;
            cr_p = s2_cr;
        end
        if (CR_FIRST != 0) begin
            first_c  = cr_p;
            second_c = cb_p;
        end else begin
            first_c  = cb_p;
            second_c = cr_p;
        end
    end

    // Even slot emits the first pair value and parks the second; odd slot drains the hold register
    always_comb begin
        c_next    = '0;
        hold_next = hold;
        if (s2_href) begin
            if (!s2_phase) begin
                c_next    = first_c;
                hold_next = paired ? second_c : '0;
            end else begin
                c_next    = hold;
                hold_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_ok          <= 1'b0;
            last_href        <= 1'b0;
            phase            <= 1'b0;
            s1_vsync         <= 1'b0;
            s1_href          <= 1'b0;
            s1_phase         <= 1'b0;
            s1_y             <= '0;
            s1_cb            <= '0;
            s1_cr            <= '0;
            s2_vsync         <= 1'b0;
            s2_href          <= 1'b0;
            s2_phase         <= 1'b0;
            s2_y             <= '0;
            s2_cb            <= '0;
            s2_cr            <= '0;
            s3_phase         <= 1'b0;
            hold             <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Y       <= '0;
            post_img_C       <= '0;
            post_odd_line    <= 1'b0;
        end else begin
            post_frame_clken <= per_frame_clken;
            post_odd_line    <= per_frame_clken & post_frame_href & ~s2_href & ~s3_phase;
            if (!per_frame_href) begin
                line_ok <= 1'b1;
            end
            if (per_frame_clken) begin
                last_href <= accept;
                if (accept) begin
                    phase <= ~cur_phase;
                end
                s1_vsync         <= per_frame_vsync;
                s1_href          <= accept;
                s1_phase         <= accept ? cur_phase : 1'b0;
                s1_y             <= accept ? per_img_Y  : '0;
                s1_cb            <= accept ? per_img_Cb : '0;
                s1_cr            <= accept ? per_img_Cr : '0;
                s2_vsync         <= s1_vsync;
                s2_href          <= s1_href;
                s2_phase         <= s1_phase;
                s2_y             <= s1_y;
                s2_cb            <= s1_cb;
                s2_cr            <= s1_cr;
                s3_phase         <= s2_phase;
                hold             <= hold_next;
                post_frame_vsync <= s2_vsync;
                post_frame_href  <= s2_href;
                post_img_Y       <= s2_href ? s2_y : '0;
                post_img_C       <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_image_ycbcr444_ycbcr422_ds.sv
// tb/tb_image_ycbcr444_ycbcr422_ds.sv - scoreboard bench over default, cosited/Cr-first and 10-bit instances
module tb_image_ycbcr444_ycbcr422_ds;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs, hr, ce;
    logic [9:0] y_in, cb_in, cr_in;

    logic [7:0] y0, c0, y1, c1;
    logic [9:0] y2, c2;
    logic       vs_o[3], hr_o[3], ce_o[3], odd_o[3];
    logic [9:0] oy[3], oc[3];

    always #5 clk = ~clk;

    image_ycbcr444_ycbcr422_ds #(.DW(8), .MODE_AVG(1), .CR_FIRST(0)) u_def (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
        .per_img_Y(y_in[7:0]), .per_img_Cb(cb_in[7:0]), .per_img_Cr(cr_in[7:0]),
        .post_frame_vsync(vs_o[0]), .post_frame_href(hr_o[0]), .post_frame_clken(ce_o[0]),
        .post_img_Y(y0), .post_img_C(c0), .post_odd_line(odd_o[0]));

    image_ycbcr444_ycbcr422_ds #(.DW(8), .MODE_AVG(0), .CR_FIRST(1)) u_alt (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
        .per_img_Y(y_in[7:0]), .per_img_Cb(cb_in[7:0]), .per_img_Cr(cr_in[7:0]),
        .post_frame_vsync(vs_o[1]), .post_frame_href(hr_o[1]), .post_frame_clken(ce_o[1]),
        .post_img_Y(y1), .post_img_C(c1), .post_odd_line(odd_o[1]));

    image_ycbcr444_ycbcr422_ds #(.DW(10), .MODE_AVG(1), .CR_FIRST(0)) u_w10 (
        .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
        .per_img_Y(y_in), .per_img_Cb(cb_in), .per_img_Cr(cr_in),
        .post_frame_vsync(vs_o[2]), .post_frame_href(hr_o[2]), .post_frame_clken(ce_o[2]),
        .post_img_Y(y2), .post_img_C(c2), .post_odd_line(odd_o[2]));

    always_comb begin
        oy[0] = {2'b00, y0};
        oc[0] = {2'b00, c0};
        oy[1] = {2'b00, y1};
        oc[1] = {2'b00, c1};
        oy[2] = y2;
        oc[2] = c2;
    end

    logic [19:0] q0[$], q1[$], q2[$];
    logic [19:0] last_exp[3];
    logic        prev_href[3];
    int          odd_seen[3];
    int          exp_odd;
    int          n_cmp = 0, n_bad = 0;
    logic        prev_ce = 1'b0;
    logic        mon_en = 1'b0, rchk = 1'b0, fin_req = 1'b0, fin_done = 1'b0;

    logic [9:0] ly[8], lcb[8], lcr[8], e0[8], e1[8], e2[8];

    always @(posedge clk) prev_ce <= ce;

    always @(negedge clk) begin : monitor
        logic [19:0] e;
        bit          got;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n && rchk) begin
                n_cmp++;
                if ({oy[d], oc[d], hr_o[d], vs_o[d], ce_o[d], odd_o[d]} != '0) begin
                    n_bad++;
                    $display("FAIL reset_zero dut%0d: y=%0d c=%0d href=%0b vs=%0b ce=%0b odd=%0b, required all 0",
                             d, oy[d], oc[d], hr_o[d], vs_o[d], ce_o[d], odd_o[d]);
                end
                prev_href[d] = 1'b0;
            end else if (mon_en && rst_n) begin
                n_cmp++;
                if (ce_o[d] !== prev_ce) begin
                    n_bad++;
                    $display("FAIL clken_delay dut%0d: got %0b required %0b", d, ce_o[d], prev_ce);
                end
                if (hr_o[d] && ce_o[d]) begin
                    got = 0;
                    e   = '0;
                    case (d)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
                    endcase
                    n_cmp++;
                    if (!got) begin
                        n_bad++;
                        $display("FAIL unexpected_pixel dut%0d: y=%0d c=%0d, required no output", d, oy[d], oc[d]);
                    end else if ({oy[d], oc[d]} !== e) begin
                        n_bad++;
                        $display("FAIL pixel dut%0d: y=%0d c=%0d required y=%0d c=%0d",
                                 d, oy[d], oc[d], e[19:10], e[9:0]);
                    end
                    last_exp[d] = e;
                end else if (hr_o[d]) begin
                    n_cmp++;
                    if ({oy[d], oc[d]} !== last_exp[d]) begin
                        n_bad++;
                        $display("FAIL stall_hold dut%0d: y=%0d c=%0d required y=%0d c=%0d",
                                 d, oy[d], oc[d], last_exp[d][19:10], last_exp[d][9:0]);
                    end
                end else begin
                    n_cmp++;
                    if (oy[d] !== 10'd0 || oc[d] !== 10'd0) begin
                        n_bad++;
                        $display("FAIL blank_zero dut%0d: y=%0d c=%0d required 0", d, oy[d], oc[d]);
                    end
                end
                if (odd_o[d]) begin
                    odd_seen[d]++;
                    n_cmp++;
                    if (!(prev_href[d] && !hr_o[d])) begin
                        n_bad++;
                        $display("FAIL odd_align dut%0d: prev_href=%0b href=%0b required 1 then 0",
                                 d, prev_href[d], hr_o[d]);
                    end
                end
                prev_href[d] = hr_o[d];
            end
        end
        if (fin_req && !fin_done) begin
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (odd_seen[d] != exp_odd) begin
                    n_bad++;
                    $display("FAIL odd_count dut%0d: got %0d required %0d", d, odd_seen[d], exp_odd);
                end
            end
            n_cmp++;
            if (q0.size() + q1.size() + q2.size() != 0) begin
                n_bad++;
                $display("FAIL leftover_expected: got %0d/%0d/%0d required 0",
                         q0.size(), q1.size(), q2.size());
            end
            fin_done = 1'b1;
        end
    end

    task automatic pix(input logic h, input logic e, input logic [9:0] y, input logic [9:0] cb, input logic [9:0] cr);
        @(negedge clk);
        hr = h; ce = e; y_in = y; cb_in = cb; cr_in = cr;
    endtask

    task automatic mid();
        @(posedge clk);
        #2;
    endtask

    task automatic run_line(input int n, input bit stall);
        for (int i = 0; i < n; i++) begin
            q0.push_back({ly[i] & 10'h0FF, e0[i]});
            q1.push_back({ly[i] & 10'h0FF, e1[i]});
            q2.push_back({ly[i], e2[i]});
            pix(1'b1, 1'b1, ly[i], lcb[i], lcr[i]);
            if (stall) pix(1'b1, 1'b0, 10'h3A5, 10'h15A, 10'h2C3);
        end
        if (n % 2 == 1) exp_odd++;
        for (int i = 0; i < 5; i++) pix(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
    endtask

    task automatic load_l1();
        ly  = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd0, 10'd0, 10'd0, 10'd0};
        lcb = '{10'd100, 10'd101, 10'd200, 10'd200, 10'd0, 10'd0, 10'd0, 10'd0};
        lcr = '{10'd50, 10'd52, 10'd0, 10'd255, 10'd0, 10'd0, 10'd0, 10'd0};
        e0  = '{10'd101, 10'd51, 10'd200, 10'd128, 10'd0, 10'd0, 10'd0, 10'd0};
        e1  = '{10'd50, 10'd100, 10'd0, 10'd200, 10'd0, 10'd0, 10'd0, 10'd0};
        e2  = e0;
    endtask

    initial begin
        exp_odd = 0;
        for (int d = 0; d < 3; d++) begin
            odd_seen[d] = 0;
            prev_href[d] = 1'b0;
            last_exp[d] = '0;
        end
        rst_n = 1'b0; rchk = 1'b1;
        vs = 1'b0; hr = 1'b0; ce = 1'b0; y_in = '0; cb_in = '0; cr_in = '0;
        repeat (3) @(negedge clk);
        mid();
        rst_n = 1'b1; rchk = 1'b0;
        vs = 1'b1;
        repeat (2) pix(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        mid();
        mon_en = 1'b1;
        vs = 1'b0;

        load_l1();
        run_line(4, 1'b0);

        ly  = '{10'd1, 10'd2, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        lcb = '{10'd8, 10'd8, 10'd9, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        lcr = '{10'd4, 10'd4, 10'd7, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        e0  = '{10'd8, 10'd4, 10'd9, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        e1  = '{10'd4, 10'd8, 10'd7, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        e2  = e0;
        run_line(3, 1'b0);

        load_l1();
        run_line(4, 1'b1);

        ly  = '{10'd1023, 10'd5, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        lcb = '{10'd1023, 10'd1023, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        lcr = '{10'd1023, 10'd1021, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        e0  = '{10'd255, 10'd254, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        e1  = '{10'd255, 10'd255, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        e2  = '{10'd1023, 10'd1022, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        run_line(2, 1'b0);

        // Reset lands mid-line while pixels are on the outputs, releases with href still high
        mid();
        mon_en = 1'b0;
        load_l1();
        for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, ly[i], lcb[i], lcr[i]);
        mid();
        rst_n = 1'b0; rchk = 1'b1;
        pix(1'b1, 1'b1, 10'd50, 10'd60, 10'd70);
        pix(1'b1, 1'b1, 10'd51, 10'd61, 10'd71);
        mid();
        rst_n = 1'b1; rchk = 1'b0;
        for (int d = 0; d < 3; d++) prev_href[d] = 1'b0;
        pix(1'b1, 1'b1, 10'd52, 10'd62, 10'd72);
        mid();
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) pix(1'b1, 1'b1, 10'd53 + 10'(i), 10'd63, 10'd73);
        for (int i = 0; i < 4; i++) pix(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        run_line(4, 1'b0);

        repeat (4) pix(1'b0, 1'b1, 10'd0, 10'd0, 10'd0);
        mid();
        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) @(posedge clk);
        if (!fin_done) begin
            $display("FAIL end_checks: monitor did not complete final checks within 10 cycles");
            $fatal(1, "end checks timed out");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/image_ycbcr444_ycbcr422_ds.md
IMAGE_YCBCR444_YCBCR422_DS -- requirements
Module: image_ycbcr444_ycbcr422_ds

Interface
REQ-001 The block SHALL have parameter DW, default 8, component bit width.
REQ-002 The block SHALL have parameter MODE_AVG, default 1: 1 = average chroma over each pixel pair, 0 = cosited decimation (even pixel chroma).
REQ-003 The block SHALL have parameter CR_FIRST, default 0: 0 = even pixel carries Cb and odd carries Cr; 1 = swapped.
REQ-004 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port per_frame_vsync, input, 1, input frame sync.
REQ-007 The block SHALL have port per_frame_href, input, 1, input line valid.
REQ-008 The block SHALL have port per_frame_clken, input, 1, pixel enable; pipeline advances only when high.
REQ-009 The block SHALL have ports per_img_Y, per_img_Cb and per_img_Cr, input, DW each, YCbCr 4:4:4 sample.
REQ-010 The block SHALL have ports post_frame_vsync, post_frame_href and post_frame_clken, output, 1 each, delayed syncs and enable.
REQ-011 The block SHALL have port post_img_Y, output, DW, luma.
REQ-012 The block SHALL have port post_img_C, output, DW, chroma (Cb or Cr per pixel phase).
REQ-013 The block SHALL have port post_odd_line, output, 1, one-cycle pulse when an input line has an odd pixel count.

Function
REQ-014 An accepted pixel SHALL be a cycle with per_frame_clken=1 and per_frame_href=1.
REQ-015 The pixel phase SHALL toggle on each accepted pixel and SHALL be forced to 0 on the first accepted pixel after per_frame_href was low.
REQ-016 The pipeline SHALL be three register stages, all loaded only on cycles with per_frame_clken=1; when per_frame_clken=0, every stage and all data outputs SHALL hold.
REQ-017 vsync and href SHALL travel through the same three enabled stages, so a sample accepted on enabled edge k appears on the outputs after enabled edge k+2.
REQ-018 post_frame_clken SHALL equal per_frame_clken delayed by one clk cycle, independent of href.
REQ-019 post_img_Y SHALL equal the luma of the pixel in the output slot, unmodified.
REQ-020 With MODE_AVG=1, the pair chroma SHALL be Cb_p=(Cb0+Cb1+1)>>1 and Cr_p=(Cr0+Cr1+1)>>1.
REQ-021 Pair-chroma sums SHALL be computed at DW+1 bits with no overflow and no saturation.
REQ-022 With MODE_AVG=0, Cb_p SHALL be Cb0 and Cr_p SHALL be Cr0.
REQ-023 The even output pixel SHALL carry Cb_p and the odd output pixel Cr_p; with CR_FIRST=1 this order SHALL be swapped.
REQ-024 The first chroma value of a pair SHALL be computed when the odd partner is one stage behind, and the second SHALL be stored in a hold register for the next slot.
REQ-025 For an unpaired last pixel (href falls while its partner is missing), the pixel SHALL use its own Cb/Cr as partner values, so the output C equals the first-order component of that pixel.
REQ-026 For an unpaired last pixel, the hold register SHALL be discarded.
REQ-027 post_odd_line SHALL pulse for one clk cycle, aligned with the post_frame_href falling edge, when the completed line contained an odd number of accepted pixels.
REQ-028 Outside post_frame_href, post_img_Y and post_img_C SHALL be 0.
REQ-029 The line pixel phase SHALL persist across clken stalls inside a line.

Reset
REQ-030 While rst_n=0, all stages, the phase, the hold register and all outputs SHALL be 0, immediately and independent of clk.
REQ-031 On rst_n rising mid-line, the first accepted pixel SHALL be treated as phase 0 only after href is seen low; pixels before that SHALL be dropped, with post_frame_href kept 0.
REQ-032 Reset SHALL NOT produce a post_odd_line pulse.

Verification
REQ-033 With defaults, clken=1, and a 4-pixel line of Y=10,20,30,40, Cb=100,101,200,200, Cr=50,52,0,255: post_img_Y SHALL be 10,20,30,40 and post_img_C SHALL be 101,51,200,128, starting 3 edges after the first pixel.
REQ-034 With MODE_AVG=0, CR_FIRST=1 and the same line: post_img_C SHALL be 50,100,0,200.
REQ-035 With a 3-pixel line Y=1,2,3, Cb=8,8,9, Cr=4,4,7: post_img_C SHALL be 8,4,9, and post_odd_line SHALL pulse once with the href fall.
REQ-036 With clken toggling 1,0,1,0 during a 4-pixel line: outputs SHALL hold in stall cycles, values SHALL match REQ-033, and post_frame_clken SHALL equal clken delayed by 1.
REQ-037 With DW=10 and Cb0=Cb1=1023: the average SHALL be 1023, with no wrap.
REQ-038 With rst_n asserted mid-line, then released mid-line: all outputs SHALL be 0 immediately, and no output SHALL appear until the next full line, which starts at phase 0.
